// File: rtl/two_bit_multiplier_3.sv
// Shift-add multiplier for a multiplier of the form 2^bi, 2^bi + 2^bj or 2^bi - 2^bj.
// One shift per term with a single add/subtract; a vld/result_vld handshake frames each request.
module two_bit_multiplier_3 #(
    parameter int unsigned N = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   a,
    input  logic [N-1:0]  b_i,
    input  logic [N-1:0]  b_j,
    input  logic          one_term,
    input  logic          b_sign,
    input  logic          vld,
    output logic [31:0]   c,
    output logic          result_vld
);

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 2 * AW;

    typedef enum logic [1:0] {
        StIdle,
        StTerm1,
        StTerm2,
        StDone
    } state_e;

    state_e         state_q;
    logic [AW-1:0]  a_q;
    logic [N-1:0]   b_i_q;
    logic [N-1:0]   b_j_q;
    logic           one_term_q;
    logic           b_sign_q;
    logic [CW-1:0]  acc_q;
    logic           result_vld_q;

    logic [CW-1:0]  a_ext;
    logic [CW-1:0]  term_i;
    logic [CW-1:0]  term_j;

    // Zero-extend before shifting so large shift amounts wrap modulo 2^32.
    assign a_ext  = {{(CW - AW){1'b0}}, a_q};
    assign term_i = a_ext << b_i_q;
    assign term_j = a_ext << b_j_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            a_q          <= '0;
            b_i_q        <= '0;
            b_j_q        <= '0;
            one_term_q   <= 1'b0;
            b_sign_q     <= 1'b0;
            acc_q        <= '0;
            result_vld_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (vld) begin
                        a_q        <= a;
                        b_i_q      <= b_i;
                        b_j_q      <= b_j;
                        one_term_q <= one_term;
                        b_sign_q   <= b_sign;
                        state_q    <= StTerm1;
                    end
                end
                StTerm1: begin
                    acc_q        <= term_i;
                    result_vld_q <= one_term_q;
                    state_q      <= one_term_q ? StDone : StTerm2;
                end
                StTerm2: begin
                    acc_q        <= b_sign_q ? (acc_q - term_j) : (acc_q + term_j);
                    result_vld_q <= 1'b1;
                    state_q      <= StDone;
                end
                StDone: begin
                    // Hold the result until the requester releases vld.
                    if (!vld) begin
                        result_vld_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    result_vld_q <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end

    assign c          = acc_q;
    assign result_vld = result_vld_q;

endmodule

// File: tb/tb_two_bit_multiplier_3.sv
// Directed and swept checks of two_bit_multiplier_3 with a queue-based scoreboard.
// Latency n means result_vld is first seen high just before the n-th edge after the sampling edge.
module tb_two_bit_multiplier_3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [3:0]  b_i;
    logic [3:0]  b_j;
    logic        one_term;
    logic        b_sign;
    logic        vld;
    logic [31:0] c;
    logic        result_vld;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] sb[$];

    two_bit_multiplier_3 #(.N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b_i        (b_i),
        .b_j        (b_j),
        .one_term   (one_term),
        .b_sign     (b_sign),
        .vld        (vld),
        .c          (c),
        .result_vld (result_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [15:0] aa, input logic [3:0] bi,
                                          input logic [3:0] bj, input logic ot, input logic bs);
        logic [31:0] t1;
        logic [31:0] t2;
        t1 = {16'h0, aa} << bi;
        t2 = {16'h0, aa} << bj;
        if (ot) return t1;
        return bs ? (t1 - t2) : (t1 + t2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Wait (bounded) for result_vld; returns the latency or 99 on timeout.
    task automatic wait_result(output int lat);
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            seen = result_vld;
        end
        if (!seen) lat = 99;
    endtask

    task automatic run_req(input logic [15:0] aa, input logic [3:0] bi, input logic [3:0] bj,
                           input logic ot, input logic bs, input int hold, input string tag);
        int lat;
        logic [31:0] exp;
        @(negedge clk);
        a = aa; b_i = bi; b_j = bj; one_term = ot; b_sign = bs; vld = 1'b1;
        sb.push_back(model(aa, bi, bj, ot, bs));
        wait_result(lat);
        check({tag, "_latency"}, lat, ot ? 32'd2 : 32'd3);
        exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        check({tag, "_c"}, c, exp);
        // Inputs changing after capture must not disturb the result.
        a = ~aa; b_i = ~bi; b_j = ~bj; one_term = ~ot; b_sign = ~bs;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_vld"}, {31'h0, result_vld}, 32'd1);
            check({tag, "_hold_c"}, c, exp);
        end
        vld = 1'b0;
        @(negedge clk);
        check({tag, "_drop_vld"}, {31'h0, result_vld}, 32'd0);
        check({tag, "_c_kept"}, c, exp);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [3:0] bj_list[11];
        logic [31:0] exp;
        bj_list = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd12};
        rst = 1'b1; vld = 1'b0; a = '0; b_i = '0; b_j = '0; one_term = 1'b0; b_sign = 1'b0;

        do_reset();
        @(negedge clk);
        check("reset_vld", {31'h0, result_vld}, 32'd0);
        check("reset_c", c, 32'd0);

        run_req(16'd3, 4'd2, 4'd0, 1'b1, 1'b0, 3, "one_term");
        run_req(16'd5, 4'd3, 4'd1, 1'b0, 1'b0, 2, "add");
        run_req(16'd5, 4'd3, 4'd1, 1'b0, 1'b1, 1, "sub");
        run_req(16'd7, 4'd0, 4'd2, 1'b0, 1'b1, 0, "neg");
        run_req(16'hFFFF, 4'd15, 4'd15, 1'b0, 1'b0, 0, "max_add");
        run_req(16'hFFFF, 4'd15, 4'd15, 1'b0, 1'b1, 0, "max_sub");
        check("const_neg", model(16'd7, 4'd0, 4'd2, 1'b0, 1'b1), 32'hFFFF_FFEB);

        // Reset during TERM2 discards the operation.
        @(negedge clk);
        a = 16'd9; b_i = 4'd4; b_j = 4'd2; one_term = 1'b0; b_sign = 1'b0; vld = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; vld = 1'b0;
        check("abort_vld", {31'h0, result_vld}, 32'd0);
        check("abort_c", c, 32'd0);
        @(negedge clk);
        check("abort_idle_vld", {31'h0, result_vld}, 32'd0);
        run_req(16'd2, 4'd1, 4'd0, 1'b1, 1'b0, 0, "after_abort");

        // vld dropped during TERM1 still yields exactly one result pulse.
        @(negedge clk);
        a = 16'd11; b_i = 4'd5; b_j = 4'd1; one_term = 1'b0; b_sign = 1'b1; vld = 1'b1;
        exp = model(16'd11, 4'd5, 4'd1, 1'b0, 1'b1);
        @(negedge clk);
        vld = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (result_vld) begin
                pulses++;
                check("early_drop_c", c, exp);
            end
        end
        check("early_drop_pulses", pulses, 32'd1);

        // Sweep with reset between requests.
        for (int ia = 0; ia < 15; ia++) begin
            for (int ib = 0; ib < 15; ib++) begin
                for (int s = 0; s < 2; s++) begin
                    for (int jj = 0; jj < 11; jj++) begin
                        do_reset();
                        run_req(16'(ia), 4'(ib), bj_list[jj], 1'b0, s[0], 0, "sweep2");
                    end
                    do_reset();
                    run_req(16'(ia), 4'(ib), 4'($urandom_range(15)), 1'b1, s[0], 0, "sweep1");
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
